// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//
// Two-requester arbiter for the shared 8-bit system bus. Requester 0 is the
// CPU, requester 1 the DMA/VGA fetch engine. One transfer owns the bus at a
// time. The owner's address/data/strobes are forwarded combinationally, and
// read data and ack are routed back to the owner only. A transfer the slave
// never acknowledges is force-terminated after TIMEOUT owned cycles. The
// terminated transfer returns ack with data 8'hFF.
//
// Build option:
//   BUSARB_RR_EN  defined   -> round-robin tie break (last-grant register)
//                 undefined -> fixed priority, m1 wins every tie
//
// Parameters:
//   AW       address width
//   DW       data width
//   TIMEOUT  owned cycles before forced termination (1..255)
//
// Ports:
//   i_clk, i_reset                    clock, synchronous active-high reset
//   i_m0_addr/dat/cs/we               requester 0 request
//   o_m0_dat/ack                      requester 0 read data / transfer done
//   i_m1_addr/dat/cs/we               requester 1 request
//   o_m1_dat/ack                      requester 1 read data / transfer done
//   o_addr/dat/cs/we                  shared bus request to the slave decode
//   i_dat/ack                         shared bus read data / ack from slaves
//   o_grant                           one-hot owner (bit0 m0, bit1 m1)
//   o_timeout                         one-cycle forced-termination pulse
// -----------------------------------------------------------------------------
module bus_arbiter #(
    parameter int AW      = 16,
    parameter int DW      = 8,
    parameter int TIMEOUT = 255
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic [AW-1:0] i_m0_addr,
    input  logic [DW-1:0] i_m0_dat,
    input  logic          i_m0_cs,
    input  logic          i_m0_we,
    output logic [DW-1:0] o_m0_dat,
    output logic          o_m0_ack,
    input  logic [AW-1:0] i_m1_addr,
    input  logic [DW-1:0] i_m1_dat,
    input  logic          i_m1_cs,
    input  logic          i_m1_we,
    output logic [DW-1:0] o_m1_dat,
    output logic          o_m1_ack,
    output logic [AW-1:0] o_addr,
    output logic [DW-1:0] o_dat,
    output logic          o_cs,
    output logic          o_we,
    input  logic [DW-1:0] i_dat,
    input  logic          i_ack,
    output logic [1:0]    o_grant,
    output logic          o_timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    // Counter value seen during the TIMEOUT-th owned cycle.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t     r_state;
    logic [7:0] r_cnt;

    logic w_own0;
    logic w_own1;
    logic w_cs;
    logic w_timeout;
    logic w_done;
    logic w_pick1;

    assign w_own0 = (r_state == OWN0);
    assign w_own1 = (r_state == OWN1);

    // Owner's chip select; zero in IDLE.
    assign w_cs = (w_own0 & i_m0_cs) | (w_own1 & i_m1_cs);

    // Only a live, unacknowledged transfer can time out. An abort (cs low)
    // ends quietly even if it lands on the last allowed cycle.
    assign w_timeout = w_cs & ~i_ack & (r_cnt == TO_LAST);

    // Any of: slave ack, owner abort, forced termination.
    assign w_done = i_ack | ~w_cs | w_timeout;

`ifdef BUSARB_RR_EN
    // 1 = m1 was granted last. Reset to m1 so that m0 wins the first tie.
    logic r_last1;

    assign w_pick1 = i_m1_cs & (~i_m0_cs | ~r_last1);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_last1 <= 1'b1;
        end else if (r_state == IDLE && (i_m0_cs || i_m1_cs)) begin
            r_last1 <= w_pick1;
        end
    end
`else
    // Fixed priority: m1 wins whenever it requests.
    assign w_pick1 = i_m1_cs;
`endif

    // NOTE: state registers use non-blocking assignments so that every
    // always_ff reads pre-edge values regardless of evaluation order.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt <= 8'd0;
                    if (i_m0_cs || i_m1_cs) begin
                        r_state <= w_pick1 ? OWN1 : OWN0;
                    end
                end
                OWN0, OWN1: begin
                    if (w_done) begin
                        r_state <= IDLE;
                        r_cnt   <= 8'd0;
                    end else if (r_cnt != 8'hFF) begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= 8'd0;
                end
            endcase
        end
    end

    // NOTE: every output gets a default at the top of the block, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        o_addr   = '0;
        o_dat    = '0;
        o_cs     = 1'b0;
        o_we     = 1'b0;
        o_m0_dat = '0;
        o_m0_ack = 1'b0;
        o_m1_dat = '0;
        o_m1_ack = 1'b0;
        if (w_own0) begin
            o_addr   = i_m0_addr;
            o_dat    = i_m0_dat;
            o_cs     = i_m0_cs;
            o_we     = i_m0_we & i_m0_cs;
            o_m0_dat = w_timeout ? '1 : i_dat;
            o_m0_ack = (i_ack & i_m0_cs) | w_timeout;
        end else if (w_own1) begin
            o_addr   = i_m1_addr;
            o_dat    = i_m1_dat;
            o_cs     = i_m1_cs;
            o_we     = i_m1_we & i_m1_cs;
            o_m1_dat = w_timeout ? '1 : i_dat;
            o_m1_ack = (i_ack & i_m1_cs) | w_timeout;
        end
    end

    assign o_grant   = {w_own1, w_own0};
    assign o_timeout = w_timeout;

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
//
// Self-checking bench for bus_arbiter (TIMEOUT = 4). It runs directed
// scenarios with constant expectations and then a randomized run. The random
// run is compared every cycle against a transfer-level reference model.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

    localparam int AW = 16;
    localparam int DW = 8;
    localparam int TO = 4;
`ifdef BUSARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          i_reset;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_dat, m1_dat;
    logic          m0_cs, m0_we, m1_cs, m1_we;
    logic [DW-1:0] o_m0_dat, o_m1_dat, o_dat;
    logic          o_m0_ack, o_m1_ack, o_cs, o_we, o_timeout;
    logic [AW-1:0] o_addr;
    logic [1:0]    o_grant;
    logic [DW-1:0] s_dat;
    logic          s_ack;
    logic          zw;      // zero-wait slave: ack follows o_cs
    logic          w_ack;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign w_ack = zw ? o_cs : s_ack;

    bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .i_clk     (clk),
        .i_reset   (i_reset),
        .i_m0_addr (m0_addr),
        .i_m0_dat  (m0_dat),
        .i_m0_cs   (m0_cs),
        .i_m0_we   (m0_we),
        .o_m0_dat  (o_m0_dat),
        .o_m0_ack  (o_m0_ack),
        .i_m1_addr (m1_addr),
        .i_m1_dat  (m1_dat),
        .i_m1_cs   (m1_cs),
        .i_m1_we   (m1_we),
        .o_m1_dat  (o_m1_dat),
        .o_m1_ack  (o_m1_ack),
        .o_addr    (o_addr),
        .o_dat     (o_dat),
        .o_cs      (o_cs),
        .o_we      (o_we),
        .i_dat     (s_dat),
        .i_ack     (w_ack),
        .o_grant   (o_grant),
        .o_timeout (o_timeout)
    );

    // ---------------- reference model (transfer level) ----------------
    // m_owner: 0 none, 1 requester 0, 2 requester 1
    // m_cycles: owned cycles already completed in the current transfer
    int m_owner  = 0;
    int m_cycles = 0;
    int m_last   = 2;

    // Packed layout: {addr, dat, cs, we, m0_dat, m0_ack, m1_dat, m1_ack, grant, timeout}
    function automatic logic [46:0] model_eval();
        logic [15:0] a;
        logic [7:0]  d, rd;
        logic        cs, we, ra, to;
        if (m_owner == 0) return '0;
        a  = (m_owner == 1) ? m0_addr : m1_addr;
        d  = (m_owner == 1) ? m0_dat  : m1_dat;
        cs = (m_owner == 1) ? m0_cs   : m1_cs;
        we = (m_owner == 1) ? m0_we   : m1_we;
        to = cs && !w_ack && (m_cycles + 1 == TO);
        ra = (w_ack && cs) || to;
        rd = to ? 8'hFF : s_dat;
        if (m_owner == 1) return {a, d, cs, we & cs, rd, ra, 8'h00, 1'b0, 2'b01, to};
        return {a, d, cs, we & cs, 8'h00, 1'b0, rd, ra, 2'b10, to};
    endfunction

    function automatic logic [46:0] dut_vec();
        return {o_addr, o_dat, o_cs, o_we, o_m0_dat, o_m0_ack,
                o_m1_dat, o_m1_ack, o_grant, o_timeout};
    endfunction

    always @(posedge clk) begin : model_update
        logic [46:0] e;
        int          w;
        e = model_eval();
        if (i_reset) begin
            m_owner  <= 0;
            m_cycles <= 0;
            m_last   <= 2;
        end else if (m_owner == 0) begin
            if (m0_cs || m1_cs) begin
                if (m0_cs && m1_cs) w = RR ? ((m_last == 2) ? 1 : 2) : 2;
                else                w = m1_cs ? 2 : 1;
                m_owner  <= w;
                m_last   <= w;
                m_cycles <= 0;
            end
        end else if (w_ack || !((m_owner == 1) ? m0_cs : m1_cs) || e[0]) begin
            m_owner  <= 0;
            m_cycles <= 0;
        end else begin
            m_cycles <= m_cycles + 1;
        end
    end

    // ---------------- helpers ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_reset = 1'b0;
        m0_cs = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_dat = '0;
        m1_cs = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_dat = '0;
        s_ack = 1'b0; s_dat = '0; zw = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        i_reset = 1'b1; m0_cs = 1'b1; m1_cs = 1'b1; m1_addr = 16'hBEEF; s_ack = 1'b1;
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (dut_vec() !== 47'h0) begin
            n_fail++; $display("FAIL reset_outputs: got %h want 0", dut_vec());
        end
        next_cycle();
        idle_inputs();
        s_ack = 1'b1; s_dat = 8'hA5;
        @(negedge clk);
        n_checks++;
        if (dut_vec() !== 47'h0) begin
            n_fail++; $display("FAIL idle_ack_ignored: got %h want 0", dut_vec());
        end
        next_cycle();
        s_ack = 1'b0;
        @(negedge clk);
        n_checks++;
        if (dut_vec() !== 47'h0) begin
            n_fail++; $display("FAIL idle_stays_idle: got %h want 0", dut_vec());
        end
        next_cycle();
    endtask

    task automatic test_single_read();
        idle_inputs();
        m0_cs = 1'b1; m0_addr = 16'h1234;
        @(negedge clk);
        n_checks++;
        if ({o_grant, o_cs} !== 3'b000) begin
            n_fail++; $display("FAIL read_req_cycle: got grant=%b cs=%b want 00/0", o_grant, o_cs);
        end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if ({o_grant, o_cs, o_we, o_addr, o_m0_ack} !== {2'b01, 1'b1, 1'b0, 16'h1234, 1'b0}) begin
            n_fail++; $display("FAIL read_grant: got grant=%b cs=%b we=%b addr=%h ack=%b want 01/1/0/1234/0",
                               o_grant, o_cs, o_we, o_addr, o_m0_ack);
        end
        next_cycle();
        s_ack = 1'b1; s_dat = 8'h5A;
        @(negedge clk);
        n_checks++;
        if ({o_m0_ack, o_m0_dat, o_m1_ack, o_m1_dat} !== {1'b1, 8'h5A, 1'b0, 8'h00}) begin
            n_fail++; $display("FAIL read_ack: got m0 ack=%b dat=%h m1 ack=%b dat=%h want 1/5a/0/00",
                               o_m0_ack, o_m0_dat, o_m1_ack, o_m1_dat);
        end
        next_cycle();
        m0_cs = 1'b0; s_ack = 1'b0;
        @(negedge clk);
        n_checks++;
        if (o_grant !== 2'b00) begin
            n_fail++; $display("FAIL read_idle_after: got grant=%b want 00", o_grant);
        end
        next_cycle();
    endtask

    task automatic test_simultaneous();
        logic [1:0] q[$];
        logic [1:0] want;
        logic [46:0] e;
        idle_inputs();
        i_reset = 1'b1;
        next_cycle();
        i_reset = 1'b0;
        zw = 1'b1;
        m0_cs = 1'b1; m0_addr = 16'($urandom); m0_dat = 8'($urandom);
        m1_cs = 1'b1; m1_addr = 16'($urandom); m1_dat = 8'($urandom);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            e = model_eval();
            n_checks++;
            if (dut_vec() !== e) begin
                n_fail++; $display("FAIL tie_model c%0d: got %h want %h", c, dut_vec(), e);
            end
            if (o_grant !== 2'b00) q.push_back(o_grant);
            next_cycle();
            // The acked requester immediately presents a new request.
            if (e[12]) begin m0_addr = 16'($urandom); m0_dat = 8'($urandom); end
            if (e[3])  begin m1_addr = 16'($urandom); m1_dat = 8'($urandom); end
        end
        n_checks++;
        if (q.size() != 4) begin
            n_fail++; $display("FAIL tie_grant_count: got %0d want 4", q.size());
        end
        for (int i = 0; i < q.size() && i < 4; i++) begin
            want = RR ? ((i % 2 == 0) ? 2'b01 : 2'b10) : 2'b10;
            n_checks++;
            if (q[i] !== want) begin
                n_fail++; $display("FAIL tie_grant_%0d: got %b want %b", i, q[i], want);
            end
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_delayed_write();
        idle_inputs();
        m1_cs = 1'b1; m1_we = 1'b1; m1_addr = 16'hF000; m1_dat = 8'h41;
        next_cycle();
        m0_cs = 1'b1; m0_addr = 16'h0100;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            n_checks++;
            if ({o_cs, o_we, o_addr, o_dat, o_m0_ack, o_m1_ack, o_grant}
                    !== {1'b1, 1'b1, 16'hF000, 8'h41, 1'b0, 1'b0, 2'b10}) begin
                n_fail++; $display("FAIL write_hold_%0d: got cs=%b we=%b addr=%h dat=%h ack0=%b ack1=%b grant=%b",
                                   k, o_cs, o_we, o_addr, o_dat, o_m0_ack, o_m1_ack, o_grant);
            end
            next_cycle();
        end
        s_ack = 1'b1; s_dat = 8'h33;
        @(negedge clk);
        n_checks++;
        if ({o_m1_ack, o_m1_dat, o_timeout, o_m0_ack} !== {1'b1, 8'h33, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL write_ack: got ack1=%b dat1=%h to=%b ack0=%b want 1/33/0/0",
                               o_m1_ack, o_m1_dat, o_timeout, o_m0_ack);
        end
        next_cycle();
        m1_cs = 1'b0; m1_we = 1'b0; s_ack = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({o_grant, o_m0_ack} !== 3'b000) begin
            n_fail++; $display("FAIL write_idle: got grant=%b ack0=%b want 00/0", o_grant, o_m0_ack);
        end
        next_cycle();
        s_ack = 1'b1; s_dat = 8'h77;
        @(negedge clk);
        n_checks++;
        if ({o_grant, o_m0_ack, o_m0_dat} !== {2'b01, 1'b1, 8'h77}) begin
            n_fail++; $display("FAIL pending_m0_served: got grant=%b ack0=%b dat0=%h want 01/1/77",
                               o_grant, o_m0_ack, o_m0_dat);
        end
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_timeout();
        idle_inputs();
        m0_cs = 1'b1; m0_addr = 16'h2000; s_dat = 8'h5A;
        next_cycle();
        for (int k = 1; k < TO; k++) begin
            @(negedge clk);
            n_checks++;
            if ({o_grant, o_m0_ack, o_timeout} !== {2'b01, 1'b0, 1'b0}) begin
                n_fail++; $display("FAIL to_wait_%0d: got grant=%b ack0=%b to=%b want 01/0/0",
                                   k, o_grant, o_m0_ack, o_timeout);
            end
            next_cycle();
        end
        @(negedge clk);
        n_checks++;
        if ({o_m0_ack, o_m0_dat, o_timeout} !== {1'b1, 8'hFF, 1'b1}) begin
            n_fail++; $display("FAIL to_fire: got ack0=%b dat0=%h to=%b want 1/ff/1",
                               o_m0_ack, o_m0_dat, o_timeout);
        end
        next_cycle();
        m0_cs = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({o_grant, o_timeout} !== 3'b000) begin
            n_fail++; $display("FAIL to_pulse_end: got grant=%b to=%b want 00/0", o_grant, o_timeout);
        end
        next_cycle();
        m0_cs = 1'b1; m0_addr = 16'h2001;
        next_cycle();
        s_ack = 1'b1; s_dat = 8'h77;
        @(negedge clk);
        n_checks++;
        if ({o_grant, o_m0_ack, o_m0_dat, o_timeout} !== {2'b01, 1'b1, 8'h77, 1'b0}) begin
            n_fail++; $display("FAIL to_recover: got grant=%b ack0=%b dat0=%h to=%b want 01/1/77/0",
                               o_grant, o_m0_ack, o_m0_dat, o_timeout);
        end
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_abort();
        idle_inputs();
        m0_cs = 1'b1; m0_addr = 16'h3000; m0_we = 1'b1;
        next_cycle();
        next_cycle();
        next_cycle();
        m0_cs = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({o_cs, o_we, o_m0_ack, o_timeout, o_grant} !== {4'b0000, 2'b01}) begin
            n_fail++; $display("FAIL abort_cycle: got cs=%b we=%b ack0=%b to=%b grant=%b want 0/0/0/0/01",
                               o_cs, o_we, o_m0_ack, o_timeout, o_grant);
        end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if ({o_grant, o_timeout, o_m0_ack} !== 4'b0000) begin
            n_fail++; $display("FAIL abort_idle: got grant=%b to=%b ack0=%b want 00/0/0",
                               o_grant, o_timeout, o_m0_ack);
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_reset_during_own();
        logic [1:0] want;
        idle_inputs();
        m1_cs = 1'b1; m1_addr = 16'h4000;
        next_cycle();
        next_cycle();
        i_reset = 1'b1;
        next_cycle();
        i_reset = 1'b0; m0_cs = 1'b1; m0_addr = 16'h4100;
        @(negedge clk);
        n_checks++;
        if ({o_cs, o_grant, o_m1_ack, o_m0_ack} !== 5'b00000) begin
            n_fail++; $display("FAIL rst_own_dropped: got cs=%b grant=%b ack1=%b ack0=%b want 0/00/0/0",
                               o_cs, o_grant, o_m1_ack, o_m0_ack);
        end
        next_cycle();
        want = RR ? 2'b01 : 2'b10;
        @(negedge clk);
        n_checks++;
        if (o_grant !== want) begin
            n_fail++; $display("FAIL rst_next_tie: got grant=%b want %b", o_grant, want);
        end
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_random();
        logic        acked0, acked1;
        logic [46:0] e;
        acked0 = 1'b0; acked1 = 1'b0;
        idle_inputs();
        for (int c = 0; c < 600; c++) begin
            if (m0_cs && acked0) begin
                m0_cs = $urandom_range(0, 1) == 1;
                m0_addr = 16'($urandom); m0_dat = 8'($urandom); m0_we = 1'($urandom);
            end else if (!m0_cs) begin
                if ($urandom_range(0, 9) < 4) begin
                    m0_cs = 1'b1; m0_addr = 16'($urandom); m0_dat = 8'($urandom); m0_we = 1'($urandom);
                end
            end else if ($urandom_range(0, 99) < 3) begin
                m0_cs = 1'b0;
            end
            if (m1_cs && acked1) begin
                m1_cs = $urandom_range(0, 1) == 1;
                m1_addr = 16'($urandom); m1_dat = 8'($urandom); m1_we = 1'($urandom);
            end else if (!m1_cs) begin
                if ($urandom_range(0, 9) < 4) begin
                    m1_cs = 1'b1; m1_addr = 16'($urandom); m1_dat = 8'($urandom); m1_we = 1'($urandom);
                end
            end else if ($urandom_range(0, 99) < 3) begin
                m1_cs = 1'b0;
            end
            s_ack   = $urandom_range(0, 9) < 3;
            s_dat   = 8'($urandom);
            i_reset = $urandom_range(0, 99) == 0;
            @(negedge clk);
            e = model_eval();
            n_checks++;
            if (dut_vec() !== e) begin
                n_fail++; $display("FAIL random_c%0d: got %h want %h", c, dut_vec(), e);
            end
            acked0 = e[12];
            acked1 = e[3];
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask

    initial begin
        idle_inputs();
        i_reset = 1'b1;
        test_reset();
        test_single_read();
        test_simultaneous();
        test_delayed_write();
        test_timeout();
        test_abort();
        test_reset_during_own();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-requester arbiter for the shared 8-bit system bus. It sits between the CPU master interface and the memory/peripheral address decode, and lets a second bus master (DMA / VGA fetch engine) share memory, UART and VGA register space with the CPU. It serialises transfers, forwards the owner's address/data/strobes to the bus, routes read data and ack back to the owner, and terminates any transfer a slave fails to acknowledge.

## Interface
- AW, 16, address width
- DW, 8, data width
- TIMEOUT, 255, maximum cycles in an owned transfer before forced termination (range 1..255)

- i_clk  in  1  system clock
- i_reset  in  1  reset; one clock, synchronous, active-high
- i_m0_addr / i_m0_dat / i_m0_cs / i_m0_we  in  AW/DW/1/1  requester 0 (CPU) request
- o_m0_dat / o_m0_ack  out  DW/1  requester 0 read data, transfer done
- i_m1_addr / i_m1_dat / i_m1_cs / i_m1_we  in  AW/DW/1/1  requester 1 (DMA/VGA) request
- o_m1_dat / o_m1_ack  out  DW/1  requester 1 read data, transfer done
- o_addr / o_dat / o_cs / o_we  out  AW/DW/1/1  shared bus request to the slave decode
- i_dat / i_ack  in  DW/1  shared bus read data and ack from the slave mux
- o_grant  out  2  one-hot current owner (bit0 = m0, bit1 = m1); 00 when idle
- o_timeout  out  1  one-cycle pulse when a transfer is force-terminated

## Operation
- States: IDLE, OWN0, OWN1.
- IDLE: no bus outputs active. If any i_mX_cs is high, the next state is OWNx, chosen by the priority rule (see Configuration). Timeout counter clears.
- OWNx: bus outputs carry the owner's signals combinationally:
  - o_addr = i_mx_addr, o_dat = i_mx_dat, o_we = i_mx_we & i_mx_cs, o_cs = i_mx_cs.
  - o_mx_dat = i_dat, o_mx_ack = i_ack & i_mx_cs.
- The non-owner gets ack = 0 and dat = 8'h00; its request stays pending.
- Exits from OWNx, all to IDLE on the next clock:
  - i_ack high.
  - Owner drops i_mx_cs (abort). o_cs falls in the same cycle; no ack is issued.
  - Timeout: the counter reaches TIMEOUT-1 with no ack. In that cycle o_mx_ack = 1, o_mx_dat = 8'hFF and o_timeout = 1.
- Timeout counter: 8-bit; increments each OWN cycle without ack; clears on entry to IDLE; never wraps.
- Requesters hold cs/addr/we/dat stable from assertion until ack. They drop cs, or present a new request, in the cycle after ack.
- In IDLE all outputs are 0: o_addr = 0, o_dat = 0, o_cs = 0, o_we = 0, acks = 0, o_mX_dat = 0, o_grant = 00, o_timeout = 0.

## Timing
- Reset: state = IDLE, counter = 0, last-grant register = m1. All outputs take their IDLE values in the cycle after i_reset is sampled high.
- Reset during OWN: the transfer is dropped with no ack. The requester must re-issue it.
- Grant latency: request seen in IDLE at cycle N, so OWN and o_cs are active at N+1.
- Back-to-back transfers: with a zero-wait slave (ack = cs), ack comes at N+1 and IDLE at N+2. Peak throughput is one transfer per 2 cycles per arbiter.
- Simultaneous requests in IDLE: exactly one grant, decided by the priority rule; the loser is granted at the next IDLE.
- Request asserted while the other requester owns the bus: waits, with no ack, until the owner's transfer ends.
- Timeout fires on the TIMEOUT-th OWN cycle. TIMEOUT = 1 therefore terminates unless ack is present in the first OWN cycle.
- i_ack in IDLE is ignored.

## Configuration
- BUSARB_RR_EN defined: round-robin. On a tie the requester not granted last wins. The last-grant register updates on every OWN entry (reset value m1, so m0 wins the first tie).
- Not defined: fixed priority; m1 always wins ties. The last-grant register is not implemented.

## Test plan
- Single read by m0 of addr 16'h1234, slave acks with 8'h5A one cycle after o_cs -> o_grant = 01 at N+1; o_m0_dat = 8'h5A and o_m0_ack = 1 at ack; IDLE the cycle after.
- m0 and m1 request in the same IDLE cycle, both held for 4 transfers, zero-wait slave -> fixed priority: m1 gets every grant while it keeps requesting. RR: grants alternate m0, m1, m0, m1.
- m1 write (16'hf000, 8'h41) with ack delayed 3 cycles -> o_cs/o_we/o_addr/o_dat stable for 3 cycles; o_m0_ack stays 0 throughout although m0 is requesting.
- Slave never acks, TIMEOUT = 4 -> on the 4th OWN cycle o_m0_ack = 1, o_m0_dat = 8'hFF, one-cycle o_timeout pulse; the next request is granted normally.
- m0 drops cs after 2 OWN cycles without ack -> o_cs falls the same cycle, no ack, IDLE next cycle, no timeout pulse.
- i_reset asserted for one cycle during a stalled m1 transfer -> o_cs = 0 and o_grant = 00 the next cycle, no ack. In RR mode the next simultaneous request goes to m0.
